// File: rtl/sincronizador_pkg.sv
// Shared definitions for the serial frame synchroniser: FSM encoding,
// error-counter width and a saturating increment helper.
package sincronizador_pkg;

    typedef enum logic [1:0] {
        BUSCAR       = 2'd0,
        CONFIRMAR    = 2'd1,
        SINCRONIZADO = 2'd2,
        ILEGAL       = 2'd3
    } estado_t;

    localparam int ANCHO_ERRORES = 8;

    function automatic logic [ANCHO_ERRORES-1:0] inc_sat(input logic [ANCHO_ERRORES-1:0] v);
        if (v == {ANCHO_ERRORES{1'b1}}) begin
            return v;
        end else begin
            return v + ANCHO_ERRORES'(1);
        end
    endfunction

endpackage

// File: rtl/sincronizador_trama_ventana.sv
// Sliding serial window: shift register, fill tracking and word comparators
// evaluated on the word as it will look after the current bit is shifted in.
module ventana_serie #(
    parameter int               ANCHO        = 5,
    parameter logic [ANCHO-1:0] SECUENCIA    = 5'b10100,
    parameter logic [ANCHO-1:0] SEC_REINICIO = 5'b00000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    output logic [ANCHO-1:0] w,
    output logic             lleno,
    output logic             es_sync,
    output logic             es_reinicio
);

    localparam int FW = $clog2(ANCHO + 1);

    logic [ANCHO-1:0] sr_r;
    logic [FW-1:0]    fill_r;

    // Window is only trusted once this bit completes ANCHO sampled bits since reset
    always_comb begin
        w           = {sr_r[ANCHO-2:0], s_in};
        lleno       = (fill_r >= FW'(ANCHO - 1));
        es_sync     = lleno && (w == SECUENCIA);
        es_reinicio = lleno && (w == SEC_REINICIO);
    end

    // Shift register and saturating fill counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r   <= '0;
            fill_r <= '0;
        end else begin
            sr_r <= {sr_r[ANCHO-2:0], s_in};
            if (fill_r != FW'(ANCHO)) begin
                fill_r <= fill_r + FW'(1);
            end else begin
                fill_r <= fill_r;
            end
        end
    end

endmodule

// File: rtl/sincronizador_trama.sv
// Serial frame synchroniser: hunts for the sync word, confirms the lock,
// strobes payload words and drops lock after repeated restart words.
module sincronizador_trama
    import sincronizador_pkg::*;
#(
    parameter int               ANCHO        = 5,
    parameter logic [ANCHO-1:0] SECUENCIA    = 5'b10100,
    parameter logic [ANCHO-1:0] SEC_REINICIO = 5'b00000,
    parameter int               N_CONFIRM    = 1,
    parameter int               N_PERDIDA    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_in,
    output logic                     valido,
    output logic                     nuevo_numero,
    output logic [ANCHO-1:0]         dato,
    output logic [ANCHO_ERRORES-1:0] errores_sync
);

    localparam int              CBW      = (ANCHO > 2) ? $clog2(ANCHO) : 1;
    localparam logic [CBW-1:0]  ULT      = CBW'(ANCHO - 1);
    localparam logic [3:0]      N_CONF_L = 4'(N_CONFIRM);
    localparam logic [3:0]      N_PERD_L = 4'(N_PERDIDA);

    logic [ANCHO-1:0]         w_s;
    logic                     lleno_s, es_sync_s, es_reinicio_s, frontera_s;
    estado_t                  estado_r, estado_s;
    logic [CBW-1:0]           cnt_bit_r, cnt_bit_s;
    logic [3:0]               conf_r, conf_s, perd_r, perd_s;
    logic [ANCHO-1:0]         dato_r, dato_s;
    logic                     nuevo_r, nuevo_s, valido_r;
    logic [ANCHO_ERRORES-1:0] errores_r, errores_s;

    ventana_serie #(
        .ANCHO        (ANCHO),
        .SECUENCIA    (SECUENCIA),
        .SEC_REINICIO (SEC_REINICIO)
    ) u_ventana (
        .clk         (clk),
        .rst         (rst),
        .s_in        (s_in),
        .w           (w_s),
        .lleno       (lleno_s),
        .es_sync     (es_sync_s),
        .es_reinicio (es_reinicio_s)
    );

    // Next-state, counters and output values; only BUSCAR compares every bit
    always_comb begin
        estado_s   = estado_r;
        frontera_s = (cnt_bit_r == ULT);
        cnt_bit_s  = frontera_s ? '0 : cnt_bit_r + CBW'(1);
        conf_s     = conf_r;
        perd_s     = perd_r;
        dato_s     = dato_r;
        nuevo_s    = 1'b0;
        errores_s  = errores_r;
        case (estado_r)
            BUSCAR: begin
                if (es_sync_s) begin
                    cnt_bit_s = '0;
                    perd_s    = 4'd0;
                    if (N_CONF_L == 4'd1) begin
                        estado_s = SINCRONIZADO;
                    end else begin
                        estado_s = CONFIRMAR;
                        conf_s   = 4'd1;
                    end
                end else begin
                    estado_s = BUSCAR;
                end
            end
            CONFIRMAR: begin
                if (frontera_s && es_sync_s) begin
                    conf_s = conf_r + 4'd1;
                    if (conf_r + 4'd1 == N_CONF_L) begin
                        estado_s = SINCRONIZADO;
                        perd_s   = 4'd0;
                    end else begin
                        estado_s = CONFIRMAR;
                    end
                end else if (frontera_s) begin
                    estado_s = BUSCAR;
                    conf_s   = 4'd0;
                end else begin
                    estado_s = CONFIRMAR;
                end
            end
            SINCRONIZADO: begin
                if (frontera_s && es_reinicio_s) begin
                    if (perd_r + 4'd1 == N_PERD_L) begin
                        estado_s  = BUSCAR;
                        errores_s = inc_sat(errores_r);
                        conf_s    = 4'd0;
                        perd_s    = 4'd0;
                    end else begin
                        perd_s = perd_r + 4'd1;
                    end
                end else if (frontera_s && es_sync_s) begin
                    perd_s = 4'd0;
                end else if (frontera_s) begin
                    dato_s  = w_s;
                    nuevo_s = 1'b1;
                    perd_s  = 4'd0;
                end else begin
                    estado_s = SINCRONIZADO;
                end
            end
            default: begin
                estado_s = BUSCAR;
                conf_s   = 4'd0;
                perd_s   = 4'd0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r  <= BUSCAR;
            cnt_bit_r <= '0;
            conf_r    <= 4'd0;
            perd_r    <= 4'd0;
            dato_r    <= '0;
            nuevo_r   <= 1'b0;
            valido_r  <= 1'b0;
            errores_r <= '0;
        end else begin
            estado_r  <= estado_s;
            cnt_bit_r <= cnt_bit_s;
            conf_r    <= conf_s;
            perd_r    <= perd_s;
            dato_r    <= dato_s;
            nuevo_r   <= nuevo_s;
            valido_r  <= (estado_s == SINCRONIZADO);
            errores_r <= errores_s;
        end
    end

    assign valido       = valido_r;
    assign nuevo_numero = nuevo_r;
    assign dato         = dato_r;
    assign errores_sync = errores_r;

endmodule

// File: tb/tb_sincronizador_trama.sv
// Directed bench for sincronizador_trama: four parameterisations share one
// clock, each scenario task drives one instance and checks its outputs.
module tb_sincronizador_trama;

    logic       clk = 1'b0;
    logic [3:0] rst = 4'hF;
    logic [3:0] s_in = 4'h0;
    logic       val0, val1, val2, val3;
    logic       nn0, nn1, nn2, nn3;
    logic [4:0] d0, d1, d2;
    logic [7:0] d3;
    logic [7:0] e0, e1, e2, e3;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] q3[$];

    always #5 clk = ~clk;

    sincronizador_trama u0 (.clk(clk), .rst(rst[0]), .s_in(s_in[0]), .valido(val0),
                            .nuevo_numero(nn0), .dato(d0), .errores_sync(e0));
    sincronizador_trama #(.N_CONFIRM(2)) u1 (.clk(clk), .rst(rst[1]), .s_in(s_in[1]),
                            .valido(val1), .nuevo_numero(nn1), .dato(d1), .errores_sync(e1));
    sincronizador_trama #(.N_PERDIDA(3)) u2 (.clk(clk), .rst(rst[2]), .s_in(s_in[2]),
                            .valido(val2), .nuevo_numero(nn2), .dato(d2), .errores_sync(e2));
    sincronizador_trama #(.ANCHO(8), .SECUENCIA(8'hA5), .SEC_REINICIO(8'h00)) u3 (
                            .clk(clk), .rst(rst[3]), .s_in(s_in[3]), .valido(val3),
                            .nuevo_numero(nn3), .dato(d3), .errores_sync(e3));

    always @(negedge clk) begin
        if (nn3 === 1'b1) q3.push_back(d3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input logic b);
        s_in[d] = b;
        tick();
    endtask

    task automatic send_word(input int d, input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) drive(d, v[i]);
    endtask

    task automatic do_reset(input int d);
        rst[d]  = 1'b1;
        s_in[d] = 1'b0;
        tick();
        rst[d]  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 4'hF;
        tick();
        tick();
        rst = 4'h0;
        n_cmp++; if ({val0, val1, val2, val3} !== 4'b0000) begin n_err++;
            $display("FAIL reset_valido: got %b want 0000", {val0, val1, val2, val3}); end
        n_cmp++; if ({nn0, nn1, nn2, nn3} !== 4'b0000) begin n_err++;
            $display("FAIL reset_nuevo: got %b want 0000", {nn0, nn1, nn2, nn3}); end
        n_cmp++; if ({d0, d1, d2, d3} !== 23'd0) begin n_err++;
            $display("FAIL reset_dato: got %h want 0", {d0, d1, d2, d3}); end
        n_cmp++; if ({e0, e1, e2, e3} !== 32'd0) begin n_err++;
            $display("FAIL reset_errores: got %h want 0", {e0, e1, e2, e3}); end
    endtask

    task automatic test_defaults();
        send_word(0, 8'h1B, 5);
        send_word(0, 8'h0A, 4);
        n_cmp++; if (val0 !== 1'b0) begin n_err++;
            $display("FAIL def_prelock: got %b want 0", val0); end
        drive(0, 1'b0);
        n_cmp++; if (val0 !== 1'b1) begin n_err++;
            $display("FAIL def_lock_bit10: got %b want 1", val0); end
        n_cmp++; if (nn0 !== 1'b0) begin n_err++;
            $display("FAIL def_sync_not_emitted: got %b want 0", nn0); end
        send_word(0, 8'h0C, 4);
        drive(0, 1'b1);
        n_cmp++; if (nn0 !== 1'b1) begin n_err++;
            $display("FAIL def_strobe_bit15: got %b want 1", nn0); end
        n_cmp++; if (d0 !== 5'b11001) begin n_err++;
            $display("FAIL def_dato: got %b want 11001", d0); end
        drive(0, 1'b0);
        n_cmp++; if (nn0 !== 1'b0) begin n_err++;
            $display("FAIL def_strobe_one_cycle: got %b want 0", nn0); end
        send_word(0, 8'h00, 3);
        n_cmp++; if (val0 !== 1'b1) begin n_err++;
            $display("FAIL def_still_locked: got %b want 1", val0); end
        drive(0, 1'b0);
        n_cmp++; if (val0 !== 1'b0) begin n_err++;
            $display("FAIL def_unlock_bit20: got %b want 0", val0); end
        n_cmp++; if (e0 !== 8'd1) begin n_err++;
            $display("FAIL def_errores: got %0d want 1", e0); end
        n_cmp++; if (nn0 !== 1'b0) begin n_err++;
            $display("FAIL def_unlock_no_strobe: got %b want 0", nn0); end
    endtask

    task automatic test_confirmar();
        do_reset(1);
        send_word(1, 8'h14, 5);
        n_cmp++; if (val1 !== 1'b0) begin n_err++;
            $display("FAIL conf_first_word: got %b want 0", val1); end
        send_word(1, 8'h14, 5);
        n_cmp++; if (val1 !== 1'b1) begin n_err++;
            $display("FAIL conf_lock_bit10: got %b want 1", val1); end
        do_reset(1);
        send_word(1, 8'h14, 5);
        send_word(1, 8'h19, 5);
        n_cmp++; if (val1 !== 1'b0) begin n_err++;
            $display("FAIL conf_bad_second: got %b want 0", val1); end
        send_word(1, 8'h14, 5);
        n_cmp++; if (val1 !== 1'b0) begin n_err++;
            $display("FAIL conf_needs_another: got %b want 0", val1); end
        send_word(1, 8'h14, 5);
        n_cmp++; if (val1 !== 1'b1) begin n_err++;
            $display("FAIL conf_relock: got %b want 1", val1); end
    endtask

    task automatic test_perdida();
        send_word(2, 8'h14, 5);
        n_cmp++; if (val2 !== 1'b1) begin n_err++;
            $display("FAIL perd_lock: got %b want 1", val2); end
        send_word(2, 8'h00, 5);
        send_word(2, 8'h00, 5);
        n_cmp++; if ((val2 !== 1'b1) || (nn2 !== 1'b0)) begin n_err++;
            $display("FAIL perd_two_restarts: got val=%b nn=%b want val=1 nn=0", val2, nn2); end
        send_word(2, 8'h0F, 5);
        n_cmp++; if ((nn2 !== 1'b1) || (d2 !== 5'b01111)) begin n_err++;
            $display("FAIL perd_payload: got nn=%b dato=%b want nn=1 dato=01111", nn2, d2); end
        send_word(2, 8'h00, 5);
        send_word(2, 8'h00, 5);
        n_cmp++; if (val2 !== 1'b1) begin n_err++;
            $display("FAIL perd_count_cleared: got %b want 1", val2); end
        send_word(2, 8'h00, 5);
        n_cmp++; if ((val2 !== 1'b0) || (e2 !== 8'd1)) begin n_err++;
            $display("FAIL perd_unlock: got val=%b err=%0d want val=0 err=1", val2, e2); end
    endtask

    task automatic test_ancho8();
        q3.delete();
        send_word(3, 8'h07, 3);
        send_word(3, 8'hA5, 8);
        n_cmp++; if (val3 !== 1'b1) begin n_err++;
            $display("FAIL a8_lock: got %b want 1", val3); end
        send_word(3, 8'h3C, 8);
        n_cmp++; if ((nn3 !== 1'b1) || (d3 !== 8'h3C)) begin n_err++;
            $display("FAIL a8_3c: got nn=%b dato=%h want nn=1 dato=3c", nn3, d3); end
        send_word(3, 8'hA5, 8);
        n_cmp++; if ((nn3 !== 1'b0) || (val3 !== 1'b1)) begin n_err++;
            $display("FAIL a8_mid_sync: got nn=%b val=%b want nn=0 val=1", nn3, val3); end
        send_word(3, 8'h7E, 8);
        n_cmp++; if ((nn3 !== 1'b1) || (d3 !== 8'h7E)) begin n_err++;
            $display("FAIL a8_7e: got nn=%b dato=%h want nn=1 dato=7e", nn3, d3); end
        @(negedge clk);
        #1;
        n_cmp++; if (q3.size() != 2) begin n_err++;
            $display("FAIL a8_strobe_count: got %0d want 2", q3.size()); end
        else if ((q3[0] !== 8'h3C) || (q3[1] !== 8'h7E)) begin n_err++;
            $display("FAIL a8_strobe_data: got %h %h want 3c 7e", q3[0], q3[1]); end
    endtask

    task automatic test_reset_locked();
        send_word(0, 8'h14, 5);
        n_cmp++; if (val0 !== 1'b1) begin n_err++;
            $display("FAIL rl_lock: got %b want 1", val0); end
        send_word(0, 8'h0D, 5);
        n_cmp++; if ((nn0 !== 1'b1) || (d0 !== 5'b01101)) begin n_err++;
            $display("FAIL rl_payload: got nn=%b dato=%b want nn=1 dato=01101", nn0, d0); end
        send_word(0, 8'h05, 3);
        do_reset(0);
        n_cmp++; if ({val0, nn0, d0, e0} !== 15'd0) begin n_err++;
            $display("FAIL rl_outputs: got val=%b nn=%b dato=%b err=%0d want all 0", val0, nn0, d0, e0); end
        send_word(0, 8'h00, 2);
        n_cmp++; if (val0 !== 1'b0) begin n_err++;
            $display("FAIL rl_partial_discarded: got %b want 0", val0); end
        send_word(0, 8'h14, 5);
        n_cmp++; if (val0 !== 1'b1) begin n_err++;
            $display("FAIL rl_relock: got %b want 1", val0); end
    endtask

    task automatic test_saturacion();
        do_reset(0);
        for (int i = 0; i < 260; i++) begin
            send_word(0, 8'h14, 5);
            send_word(0, 8'h00, 5);
            if (i == 0) begin
                n_cmp++; if (e0 !== 8'd1) begin n_err++;
                    $display("FAIL sat_first: got %0d want 1", e0); end
            end else if (i == 254) begin
                n_cmp++; if (e0 !== 8'd255) begin n_err++;
                    $display("FAIL sat_reach: got %0d want 255", e0); end
            end else begin
                n_cmp = n_cmp;
            end
        end
        n_cmp++; if ((e0 !== 8'd255) || (val0 !== 1'b0)) begin n_err++;
            $display("FAIL sat_hold: got err=%0d val=%b want err=255 val=0", e0, val0); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_confirmar();
        test_perdida();
        test_ancho8();
        test_reset_locked();
        test_saturacion();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sincronizador_trama.md
# sincronizador_trama

Parametrised serial frame synchroniser that generalises the team's 5-bit single-pattern detector. It takes a 1-bit serial stream (MSB first), hunts for a sync word of `ANCHO` bits on a sliding window, and locks to the word boundary. The lock is confirmed over `N_CONFIRM` consecutive sync words. Once locked, it emits every payload word with a one-cycle strobe, and it drops lock after `N_PERDIDA` consecutive restart words. It sits between the serial line front-end and the word-level consumer.

## Interface
- `ANCHO`, 5: word width in bits; legal range is 2..32.
- `SECUENCIA`, 5'b10100: sync word, `ANCHO` bits.
- `SEC_REINICIO`, 5'b00000: restart/idle word, `ANCHO` bits; must differ from `SECUENCIA`.
- `N_CONFIRM`, 1: consecutive sync words needed to lock; legal range is 1..15.
- `N_PERDIDA`, 1: consecutive restart words needed to drop lock; legal range is 1..15.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_in` in 1: serial data, sampled every rising edge, MSB first.
- `valido` out 1: high while in SINCRONIZADO.
- `nuevo_numero` out 1: one-cycle strobe marking a completed payload word.
- `dato` out `ANCHO`: last payload word; it holds between strobes.
- `errores_sync` out 8: count of lock losses; saturates at 255.

## Operation
- **Shift register.** `sr <= {sr[ANCHO-2:0], s_in}` every cycle.
  - Word compare is done on the next value, `w = {sr[ANCHO-2:0], s_in}`.
  - State and outputs update on the same edge that samples the word's last bit.
- **Fill counter.** Counts bits sampled since reset, saturating at `ANCHO`.
  - No window compare is valid until `ANCHO` bits have been sampled.
  - This prevents false matches against reset contents.
- **Bit counter `cnt_bit`.** Range is 0..`ANCHO`-1 and it wraps.
  - It is forced to 0 on the edge where a match aligns the frame.
  - A word boundary is the edge where `cnt_bit == ANCHO-1`.
- **BUSCAR** (reset state). The sliding compare runs every cycle.
  - If `w == SECUENCIA` and `N_CONFIRM == 1`, go to SINCRONIZADO.
  - If `w == SECUENCIA` and `N_CONFIRM > 1`, go to CONFIRMAR with the confirm count at 1.
- **CONFIRMAR.** Compares only at word boundaries.
  - A sync word increments the confirm count; reaching `N_CONFIRM` goes to SINCRONIZADO.
  - Any other word returns to BUSCAR, and the sliding search restarts from the following bit.
- **SINCRONIZADO.** Compares only at word boundaries.
  - Payload word (neither sync nor restart): `dato <= w`, `nuevo_numero` pulses, loss count clears.
  - Sync word: treated as a realignment marker; not emitted, loss count clears.
  - Restart word: not emitted; loss count increments.
  - When the loss count reaches `N_PERDIDA`: go to BUSCAR, increment `errores_sync` (saturating), clear the confirm count.
  - The fill counter is not cleared, so the hunt resumes immediately.

## Timing
- **Reset values.** `valido`=0, `nuevo_numero`=0, `dato`=0, `errores_sync`=0.
  - Internal: `sr`=0, fill counter=0, `cnt_bit`=0, all counts=0, state BUSCAR.
- **Reset mid-frame.** Outputs take their reset values at the first edge where `rst` is high.
  - A word straddling the reset is discarded.
- **Latency.** `valido`, `nuevo_numero` and `dato` change at the edge that samples the last bit of the deciding word.
  - They are visible in the following cycle; there is zero additional pipeline.
- **`nuevo_numero` behaviour.**
  - Never high two cycles in a row when `ANCHO` ≥ 2.
  - Never high when `valido` is low in the same cycle.
- **Lock-loss edge.** On the edge that drops lock, `valido` falls and `errores_sync` increments together, and `nuevo_numero` is 0.
- **Overlapping patterns** (e.g. sync 1010 on input 101010). BUSCAR locks on the first complete match.
- **`rst` with a matching word on the same edge.** Reset wins.

## Structure
- **Shared package/header `sincronizador_pkg`.** Holds:
  - state encoding localparams: BUSCAR=2'd0, CONFIRMAR=2'd1, SINCRONIZADO=2'd2;
  - the width of `errores_sync` (8).
  - 2'd3 is illegal and recovers to BUSCAR.
- **Sub-module `ventana_serie`.** Parametrised by `ANCHO`. It contains:
  - the shift register and fill counter;
  - outputs `w`, `lleno`, `es_sync` and `es_reinicio`.
- **Top.** Holds the FSM, `cnt_bit`, the confirm and loss counters, and the output registers.

## Test plan
- **Defaults.** After `rst`, drive 11011, 10100, 11001, 00000 on consecutive 10 ns clocks.
  - `valido` rises after the 10th bit.
  - `nuevo_numero` pulses once with `dato`=11001 after the 15th bit.
  - `valido` falls and `errores_sync`=1 after the 20th bit.
- **`N_CONFIRM`=2.**
  - 10100, 10100 → lock after the 10th bit.
  - 10100, 11001 → no lock; back to BUSCAR.
  - A following 10100 locks again only after a further confirm word.
- **`N_PERDIDA`=3, locked.**
  - Restart words 00000, 00000, then 01111 → `dato`=01111 strobed, still locked.
  - Three consecutive 00000 → unlock, `errores_sync` increments.
- **`ANCHO`=8, `SECUENCIA`=8'hA5, `SEC_REINICIO`=8'h00.**
  - Send 3 junk bits, A5, 3C, A5, 7E → strobes carry 3C and 7E only; the mid-stream A5 is not emitted.
- **Reset while locked.** Assert `rst` for one cycle mid-word.
  - All outputs reach their reset values next cycle; `errores_sync` returns to 0.
  - Relock needs a fresh sync word; a word of partial bits before reset is not matched.
- **Saturation.** Force 260 lock/loss cycles → `errores_sync` holds at 255.
